// File: rtl/cim_pkg.sv
// Shared definitions for the compute-in-memory row: op codes, FSM states
// and a small op classification helper.
package cim_pkg;

  typedef enum logic [2:0] {
    OP_NOT   = 3'd0,
    OP_AND   = 3'd1,
    OP_NOR   = 3'd2,
    OP_XOR   = 3'd3,
    OP_ADD   = 3'd4,
    OP_ADDC  = 3'd5,
    OP_SHIFT = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops that use and update the per-lane carry register.
  function automatic logic is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_ADDC);
  endfunction

endpackage

// File: rtl/cim_lane.sv
// One bit-line compute lane: op mux, bit-serial carry register and
// registered write-back bit.
module cim_lane
  import cim_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  op_e  op,
  input  logic carry_load,
  input  logic carry_init,
  input  logic beat,
  input  logic anded,
  input  logic nored,
  input  logic xored,
  input  logic shift_bit,
  output logic wb_bit,
  output logic carry
);

  logic carry_q, carry_d;
  logic wb_q, wb_d;
  logic res;

  // Select the per-lane result for the current op.
  always_comb begin
    res = ~anded;
    case (op)
      OP_NOT:   res = ~anded;
      OP_AND:   res = anded;
      OP_NOR:   res = nored;
      OP_XOR:   res = xored;
      OP_ADD:   res = xored ^ carry_q;
      OP_ADDC:  res = xored ^ carry_q;
      OP_SHIFT: res = shift_bit;
      OP_RSVD:  res = ~anded;
      default:  res = ~anded;
    endcase
  end

  // Next carry and write-back: carry seeds on start, steps only on arithmetic beats.
  always_comb begin
    carry_d = carry_q;
    wb_d    = wb_q;
    if (carry_load) begin
      carry_d = carry_init;
    end else if (beat && is_arith(op)) begin
      carry_d = anded | (xored & carry_q);
    end
    if (beat) begin
      wb_d = res;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      wb_q    <= 1'b0;
    end else begin
      carry_q <= carry_d;
      wb_q    <= wb_d;
    end
  end

  assign wb_bit = wb_q;
  assign carry  = carry_q;

endmodule

// File: rtl/cim_compute_row.sv
// Compute-in-memory row controller: accepts an op, consumes nbits sensed
// bit-line beats and produces one registered write-back beat per input beat.
module cim_compute_row
  import cim_pkg::*;
#(
  parameter int unsigned LANES   = 8,
  parameter int unsigned MAXBITS = 16,
  localparam int unsigned CW     = $clog2(MAXBITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CW-1:0]    nbits,
  input  logic             bl_valid,
  input  logic [LANES-1:0] anded,
  input  logic [LANES-1:0] nored,
  input  logic [LANES-1:0] xored,
  input  logic             shift_in,
  output logic             wb_valid,
  output logic [LANES-1:0] wb_data,
  output logic [LANES-1:0] carry_out,
  output logic             busy,
  output logic             done
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [CW-1:0] nbits_q, nbits_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wb_valid_q, wb_valid_d;

  logic          start_acc;
  logic          beat;
  logic          carry_load;
  logic          carry_init;
  logic [CW-1:0] nbits_sat;

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign beat       = (state_q == ST_RUN) && bl_valid;
  assign carry_load = start_acc && is_arith(op_e'(op));
  assign carry_init = (op_e'(op) == OP_ADDC);
  assign nbits_sat  = (nbits > CW'(MAXBITS)) ? CW'(MAXBITS) : nbits;

  // Next-state, operand capture and beat counting.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    nbits_d    = nbits_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          nbits_d = nbits_sat;
          cnt_d   = '0;
          state_d = (nbits_sat == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bl_valid) begin
          wb_valid_d = 1'b1;
          if (cnt_q != nbits_q) begin
            cnt_d = cnt_q + CW'(1);
          end
          if ((cnt_q + CW'(1)) == nbits_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOT;
      nbits_q    <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      nbits_q    <= nbits_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  // Lane 0 shifts in from shift_in; lane i takes anded[i-1].
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic shift_bit;
    if (i == 0) begin : g_first
      assign shift_bit = shift_in;
    end else begin : g_rest
      assign shift_bit = anded[i-1];
    end

    cim_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op_q),
      .carry_load (carry_load),
      .carry_init (carry_init),
      .beat       (beat),
      .anded      (anded[i]),
      .nored      (nored[i]),
      .xored      (xored[i]),
      .shift_bit  (shift_bit),
      .wb_bit     (wb_data[i]),
      .carry      (carry_out[i])
    );
  end

  assign wb_valid = wb_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule
